// File: rtl/div8_pkg.sv
// Shared types and helpers for the round-robin shared divider (div8_shared_arbiter).
package div8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          MAX_REQ       = 4;
    localparam logic [31:0] DIV0_QUOTIENT = '1;

    // Returns the first valid requester at or after ptr, wrapping at nreq.
    function automatic logic [1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [1:0]         ptr,
                                           input int                 nreq);
        logic [1:0] pick;
        logic       found;
        int         idx;
        logic [1:0] idx2;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx  = (int'(ptr) + k) % nreq;
            idx2 = idx[1:0];
            if ((k < nreq) && !found && valid[idx2]) begin
                pick  = idx2;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/div8_iter_core.sv
// Iterative restoring divider: one quotient bit per cycle, WIDTH cycles after start.
module div8_iter_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] div_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] dvd_next;
    logic             q_bit;

    // The dividend register doubles as the quotient register: bits shift out the top, quotient bits in the bottom.
    always_comb begin
        rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
        q_bit     = (rem_shift >= {1'b0, div_q});
        rem_next  = q_bit ? (rem_shift - {1'b0, div_q}) : rem_shift;
        dvd_next  = {dvd_q[WIDTH-2:0], q_bit};
    end

    assign done      = run_q && (cnt_q == '0);
    assign quotient  = dvd_next;
    assign remainder = rem_next[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            rem_q <= '0;
            dvd_q <= '0;
            div_q <= '0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= CW'(WIDTH - 1);
            rem_q <= '0;
            dvd_q <= a;
            div_q <= b;
        end else if (run_q) begin
            rem_q <= rem_next;
            dvd_q <= dvd_next;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/div8_shared_arbiter.sv
// Round-robin arbiter sharing one iterative divider between NREQ requesters.
// Define DIV_PERF_CNT_EN to add the op_count / div0_count performance counters.
module div8_shared_arbiter
    import div8_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_quotient,
    output logic [WIDTH-1:0]      rsp_remainder,
    output logic                  rsp_div0,
    output logic                  busy
`ifdef DIV_PERF_CNT_EN
    ,
    output logic [15:0]           op_count,
    output logic [7:0]            div0_count
`endif
);

    state_t           state;
    state_t           next_state;
    logic [1:0]       rr_ptr;
    logic [1:0]       owner;
    logic [1:0]       grant;
    logic [MAX_REQ-1:0] valid_pad;
    logic             accept;
    logic             owner_ready;
    logic             core_start;
    logic             core_done;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] core_q;
    logic [WIDTH-1:0] core_r;

    assign valid_pad  = MAX_REQ'(req_valid);
    assign grant      = rr_pick(valid_pad, rr_ptr, NREQ);
    assign accept     = (state == IDLE) && (|req_valid);
    assign core_start = accept && (sel_b != '0);
    assign busy       = (state != IDLE);

    // Operand mux follows the grant; response steering follows the latched owner.
    always_comb begin
        sel_a       = '0;
        sel_b       = '0;
        owner_ready = 1'b0;
        req_ready   = '0;
        rsp_valid   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == 2'(i)) begin
                sel_a        = req_a[i*WIDTH +: WIDTH];
                sel_b        = req_b[i*WIDTH +: WIDTH];
                req_ready[i] = accept;
            end
            if (owner == 2'(i)) begin
                owner_ready  = rsp_ready[i];
                rsp_valid[i] = (state == RESP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept)      next_state = (sel_b == '0) ? RESP : CALC;
            CALC: if (core_done)   next_state = RESP;
            RESP: if (owner_ready) next_state = IDLE;
            default:               next_state = IDLE;
        endcase
    end

    // Result buses only change when a new result is produced, so they hold after the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            owner         <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_div0      <= 1'b0;
        end else begin
            if (accept) begin
                owner <= grant;
                if (sel_b == '0) begin
                    rsp_quotient  <= DIV0_QUOTIENT[WIDTH-1:0];
                    rsp_remainder <= sel_a;
                    rsp_div0      <= 1'b1;
                end
            end
            if ((state == CALC) && core_done) begin
                rsp_quotient  <= core_q;
                rsp_remainder <= core_r;
                rsp_div0      <= 1'b0;
            end
            if ((state == RESP) && owner_ready) begin
                rr_ptr <= (owner == 2'(NREQ - 1)) ? 2'd0 : owner + 2'd1;
            end
        end
    end

`ifdef DIV_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count   <= '0;
            div0_count <= '0;
        end else if ((state == RESP) && owner_ready) begin
            if (op_count != 16'hFFFF) begin
                op_count <= op_count + 16'd1;
            end
            if (rsp_div0 && (div0_count != 8'hFF)) begin
                div0_count <= div0_count + 8'd1;
            end
        end
    end
`endif

    div8_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .a         (sel_a),
        .b         (sel_b),
        .done      (core_done),
        .quotient  (core_q),
        .remainder (core_r)
    );

endmodule
